acc_wbuffer: RTL

ACC_WBUFFER -- requirements
Module: acc_wbuffer

---
 rtl/acc_wbuffer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/acc_wbuffer.sv
// Accumulating write-back buffer: collects up to 4 rows, then read-modify-writes them into memory.
// Build with ACC_WBUFFER_SAT_EN for signed saturating lane adds; default is wrap-around.
module acc_wbuffer #(
  parameter int LANE_W = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  acc,
  input  logic                  row_valid,
  input  logic [4*LANE_W-1:0]   row_data,
  input  logic [2:0]            row_total,
  input  logic [3:0]            base,
  input  logic                  omsrc,
  input  logic                  clr,
  output logic                  load_done,
  output logic                  store_done,
  output logic                  mem_re,
  output logic [3:0]            mem_raddr,
  input  logic [4*LANE_W-1:0]   mem_rdata,
  output logic                  mem_we,
  output logic [3:0]            mem_waddr,
  output logic [4*LANE_W-1:0]   mem_wdata,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, COLLECT, WAIT_BUS, STORE} state_t;

  state_t state, state_nxt;

  logic [2:0] cnt, total, r, total_in;
  logic [1:0] base_hi, wr_idx;
  logic       wr_pend;
  logic       capture, last_cap, rd_go, last_wr, stray;
  logic [4*LANE_W-1:0] rows [4];
  logic [4*LANE_W-1:0] sum;

  // The low base bits are always zero; the row index fills them.
  logic unused_base;
  assign unused_base = ^base[1:0];

  function automatic logic [LANE_W-1:0] lane_add(input logic [LANE_W-1:0] a, input logic [LANE_W-1:0] b);
    logic [LANE_W-1:0] s;
    s = a + b;
`ifdef ACC_WBUFFER_SAT_EN
    if (a[LANE_W-1] == b[LANE_W-1] && s[LANE_W-1] != a[LANE_W-1])
      s = a[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
`endif
    return s;
  endfunction

  assign total_in = (row_total == 3'd0 || row_total > 3'd4) ? 3'd4 : row_total;
  assign capture  = row_valid && acc && !clr && (state == IDLE || state == COLLECT);
  assign last_cap = capture && ((state == IDLE) ? (total_in == 3'd1) : ((cnt + 3'd1) == total));
  assign rd_go    = (state == STORE) && omsrc && (r < total);
  assign last_wr  = (state == STORE) && wr_pend && ({1'b0, wr_idx} == (total - 3'd1));
  assign stray    = row_valid && ((state == STORE) || (state == WAIT_BUS && !clr) ||
                                  (state == COLLECT && !acc && !clr));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (capture) state_nxt = last_cap ? WAIT_BUS : COLLECT;
      COLLECT:  if (clr) state_nxt = IDLE; else if (last_cap) state_nxt = WAIT_BUS;
      WAIT_BUS: if (clr) state_nxt = IDLE; else if (omsrc) state_nxt = STORE;
      STORE:    if (last_wr) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Write data is formed from the read data returned this cycle, so the write side stays combinational.
  always_comb begin
    sum = '0;
    for (int i = 0; i < 4; i++)
      sum[i*LANE_W +: LANE_W] = lane_add(mem_rdata[i*LANE_W +: LANE_W], rows[wr_idx][i*LANE_W +: LANE_W]);
  end

  always_comb begin
    mem_re    = rd_go;
    mem_raddr = rd_go ? {base_hi, r[1:0]} : 4'd0;
    mem_we    = (state == STORE) && wr_pend;
    mem_waddr = mem_we ? {base_hi, wr_idx} : 4'd0;
    mem_wdata = mem_we ? sum : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt        <= 3'd0;
      total      <= 3'd0;
      r          <= 3'd0;
      base_hi    <= 2'd0;
      wr_pend    <= 1'b0;
      wr_idx     <= 2'd0;
      load_done  <= 1'b0;
      store_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      load_done  <= last_cap;
      store_done <= last_wr;
      wr_pend    <= rd_go;
      if (stray) err <= 1'b1;
      if (rd_go) begin
        wr_idx <= r[1:0];
        r      <= r + 3'd1;
      end
      case (state)
        IDLE: if (capture) begin
          total   <= total_in;
          base_hi <= base[3:2];
          cnt     <= 3'd1;
        end
        COLLECT: begin
          if (clr)          cnt <= 3'd0;
          else if (capture) cnt <= cnt + 3'd1;
        end
        WAIT_BUS: begin
          if (clr)        cnt <= 3'd0;
          else if (omsrc) r   <= 3'd0;
        end
        STORE: if (last_wr) begin
          cnt <= 3'd0;
          r   <= 3'd0;
        end
        default: ;
      endcase
    end
  end

  // Row storage is not reset; it is always written before it is read.
  always_ff @(posedge clk) begin
    if (capture) rows[cnt[1:0]] <= row_data;
  end

endmodule
